// File: rtl/osd_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : osd_seq_pkg
//  Description : Shared types and constants for the OSD command sequencer:
//                FSM state encoding, OSD command nibbles, FIFO entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package osd_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_HI      = 3'd3,
        ST_LO      = 3'd4,
        ST_RELEASE = 3'd5
    } seq_state_t;

    localparam logic [3:0] OSD_CMD_WRITE  = 4'h2;
    localparam logic [3:0] OSD_CMD_ENABLE = 4'h4;

    localparam int ENTRY_W = 17;

    typedef struct packed {
        logic        last;
        logic [15:0] data;
    } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/osd_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : osd_cmd_sequencer_if
//  Description : Host command stream (valid/ready with last-of-transaction).
//  Revision    : 1.0 - initial release
// ============================================================================
interface osd_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic        cmd_last;

    modport master (output cmd_valid, output cmd_data, output cmd_last, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_data, input cmd_last, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/osd_seq_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : osd_seq_fifo
//  Description : Synchronous show-ahead FIFO; dout is the head entry whenever
//                empty is low. Push is ignored when full, pop when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module osd_seq_fifo
    import osd_seq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  wire logic               clk_sys,
    input  wire logic               reset,
    input  wire logic               push,
    input  wire logic               pop,
    input  wire logic [ENTRY_W-1:0] din,
    output logic                    full,
    output logic                    empty,
    output logic [ENTRY_W-1:0]      dout
);
    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); simultaneous push/pop keeps count.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/osd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : osd_cmd_sequencer
//  Description : Buffers host command words and replays them on the OSD
//                io_osd / io_strobe / io_din bus with programmable timing.
//                Optional feature macro OSD_SEQ_SHADOW_EN adds osd_on, a
//                mirror of the OSD enable state.
//  Revision    : 1.0 - initial release
// ============================================================================
module osd_cmd_sequencer
    import osd_seq_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int STB_CYC   = 2,
    parameter int SETUP_CYC = 2,
    parameter int GAP_CYC   = 4
) (
    input  wire logic          clk_sys,
    input  wire logic          reset,
    osd_cmd_sequencer_if.slave cmd,
    output logic               io_osd,
    output logic               io_strobe,
    output logic [15:0]        io_din,
    output logic               busy
`ifdef OSD_SEQ_SHADOW_EN
    ,
    output logic               osd_on
`endif
);
    localparam int CNT_BIG = (STB_CYC > SETUP_CYC) ? ((STB_CYC > GAP_CYC) ? STB_CYC : GAP_CYC)
                                                   : ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC);
    localparam int CNT_W = $clog2(CNT_BIG + 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STB_LD   = CNT_W'(STB_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

    seq_state_t         state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               osd_nx, stb_nx, lastq, lastq_nx;
    logic [15:0]        din_nx;
    logic               pop;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] head_raw;
    fifo_entry_t        head;

    assign head          = fifo_entry_t'(head_raw);
    assign cmd.cmd_ready = ~fifo_full;
    assign busy          = (state != ST_IDLE) | ~fifo_empty;

    osd_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (cmd.cmd_valid & ~fifo_full),
        .pop     (pop),
        .din     ({cmd.cmd_last, cmd.cmd_data}),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .dout    (head_raw)
    );

    // State, shared down-counter and the registered OSD bus outputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            io_osd    <= 1'b0;
            io_strobe <= 1'b0;
            io_din    <= '0;
            lastq     <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            io_osd    <= osd_nx;
            io_strobe <= stb_nx;
            io_din    <= din_nx;
            lastq     <= lastq_nx;
        end
    end

    // Next-state and next-output decode; the counter saturates at zero so LO can stall.
    always_comb begin
        state_nx = state;
        cnt_nx   = (cnt != '0) ? cnt - 1'b1 : cnt;
        osd_nx   = io_osd;
        stb_nx   = io_strobe;
        din_nx   = io_din;
        lastq_nx = lastq;
        pop      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nx = ST_SETUP;
                    osd_nx   = 1'b1;
                    cnt_nx   = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (cnt == '0) state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                pop      = 1'b1;
                din_nx   = head.data;
                lastq_nx = head.last;
                stb_nx   = 1'b1;
                cnt_nx   = STB_LD;
                state_nx = ST_HI;
            end
            ST_HI: begin
                if (cnt == '0) begin
                    state_nx = ST_LO;
                    stb_nx   = 1'b0;
                    cnt_nx   = STB_LD;
                end
            end
            ST_LO: begin
                if (cnt == '0) begin
                    if (lastq) begin
                        state_nx = ST_RELEASE;
                        osd_nx   = 1'b0;
                        cnt_nx   = GAP_LD;
                    end else if (!fifo_empty) begin
                        state_nx = ST_LOAD;
                    end
                end
            end
            ST_RELEASE: begin
                // The gap has fully elapsed here, so a queued transaction reopens
                // the frame immediately and io_osd stays low exactly GAP_CYC cycles.
                if (cnt == '0) begin
                    if (!fifo_empty) begin
                        state_nx = ST_SETUP;
                        osd_nx   = 1'b1;
                        cnt_nx   = SETUP_LD;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

`ifdef OSD_SEQ_SHADOW_EN
    logic       first_pend;
    logic [3:0] first_nib;
    logic       first_b0;

    // Capture the transaction's first word and commit the enable bit when the frame closes.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            first_pend <= 1'b0;
            first_nib  <= '0;
            first_b0   <= 1'b0;
            osd_on     <= 1'b0;
        end else begin
            if (state_nx == ST_SETUP && state != ST_SETUP) begin
                first_pend <= 1'b1;
            end
            if (state == ST_LOAD && first_pend) begin
                first_pend <= 1'b0;
                first_nib  <= head.data[7:4];
                first_b0   <= head.data[0];
            end
            if (state_nx == ST_RELEASE && state != ST_RELEASE && first_nib == OSD_CMD_ENABLE) begin
                osd_on <= first_b0;
            end
        end
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_osd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_osd_cmd_sequencer
//  Description : Self-checking bench for osd_cmd_sequencer (both builds of
//                OSD_SEQ_SHADOW_EN). Bus events are captured by a monitor and
//                compared with expectations derived from the timing rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_osd_cmd_sequencer;
    localparam int DEPTH = 16, STB = 2, SETUP = 2, GAP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_osd, io_strobe, busy;
    logic [15:0] io_din;
`ifdef OSD_SEQ_SHADOW_EN
    logic        osd_on;
    logic        obs_on[$];
    logic        exp_on[$];
`endif
    logic        model_on = 1'b0;

    osd_cmd_sequencer_if cmd_if();

    osd_cmd_sequencer #(.DEPTH(DEPTH), .STB_CYC(STB), .SETUP_CYC(SETUP), .GAP_CYC(GAP)) dut (
        .clk_sys   (clk),
        .reset     (rst),
        .cmd       (cmd_if),
        .io_osd    (io_osd),
        .io_strobe (io_strobe),
        .io_din    (io_din),
        .busy      (busy)
`ifdef OSD_SEQ_SHADOW_EN
        ,
        .osd_on    (osd_on)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state
    logic [15:0] obs_din[$];
    int          obs_rise[$], obs_hi[$], obs_setup[$], obs_tail[$], obs_gap[$];
    int          osd_rises = 0, din_glitch = 0;
    int          rise_last = 0, fall_last = 0, osd_rise_c = 0, osd_fall_c = 0;
    bit          seen_fall = 0, first_pending = 0, mon_en = 0;
    logic        p_stb = 0, p_osd = 0;
    logic [15:0] p_din = 0;

    // Host-side scoreboard
    logic [15:0] exp_q[$];
    int          push_cyc = 0, stall_cnt = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (io_strobe && !p_stb) begin
                obs_din.push_back(io_din);
                obs_rise.push_back(cyc);
                rise_last = cyc;
                if (first_pending) begin
                    obs_setup.push_back(cyc - osd_rise_c);
                    first_pending = 0;
                end
            end
            if (!io_strobe && p_stb) begin
                obs_hi.push_back(cyc - rise_last);
                fall_last = cyc;
            end
            if (io_strobe && p_stb && io_din !== p_din) din_glitch++;
            if (io_osd && !p_osd) begin
                osd_rises++;
                if (seen_fall) obs_gap.push_back(cyc - osd_fall_c);
                osd_rise_c    = cyc;
                first_pending = 1;
            end
            if (!io_osd && p_osd) begin
                obs_tail.push_back(cyc - fall_last);
                osd_fall_c = cyc;
                seen_fall  = 1;
`ifdef OSD_SEQ_SHADOW_EN
                obs_on.push_back(osd_on);
`endif
            end
        end
        p_stb = io_strobe;
        p_osd = io_osd;
        p_din = io_din;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        obs_din.delete(); obs_rise.delete(); obs_hi.delete(); obs_setup.delete();
        obs_tail.delete(); obs_gap.delete(); exp_q.delete();
        osd_rises = 0; din_glitch = 0; seen_fall = 0; first_pending = 0;
`ifdef OSD_SEQ_SHADOW_EN
        obs_on.delete(); exp_on.delete();
`endif
    endtask

    // Called at #1 after a posedge; returns at #1 after the accepting posedge.
    task automatic push_word(input logic [15:0] d, input logic l);
        int  n;
        logic r;
        bit  done;
        n = 0; done = 0; r = 0;
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_data = d; cmd_if.cmd_last = l;
        while (!done) begin
            @(negedge clk); r = cmd_if.cmd_ready;
            @(posedge clk);
            if (r) done = 1;
            else begin
                stall_cnt++; n++;
                if (n > 1000) begin check("push_timeout", 0, 1); done = 1; end
            end
        end
        #1;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_last = 1'b0;
        push_cyc = cyc;
        if (r) exp_q.push_back(d);
    endtask

    // Transaction-level shadow rule: an enable command sets osd_on to its bit0.
    function automatic logic shadow_next(input logic cur, input logic [15:0] first);
        return (first[7:4] == 4'h4) ? first[0] : cur;
    endfunction

    task automatic note_txn(input logic [15:0] first);
        model_on = shadow_next(model_on, first);
`ifdef OSD_SEQ_SHADOW_EN
        exp_on.push_back(model_on);
`endif
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (busy && n < budget);
        check("idle_timeout", busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_strobes(input int cnt_req, input int budget);
        int n;
        n = 0;
        while (obs_din.size() < cnt_req && n < budget) begin @(negedge clk); #1; n++; end
        check("strobe_timeout", obs_din.size() >= cnt_req, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, obs_din.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_din.size(); i++)
            check({tag, "_din"}, obs_din[i], exp_q[i]);
        foreach (obs_hi[i])   check({tag, "_hi_len"}, obs_hi[i], STB);
        foreach (obs_tail[i]) check({tag, "_tail"}, obs_tail[i], STB);
        foreach (obs_setup[i]) check({tag, "_setup"}, obs_setup[i], SETUP + 1);
        check({tag, "_din_glitch"}, din_glitch, 0);
`ifdef OSD_SEQ_SHADOW_EN
        check({tag, "_on_count"}, obs_on.size(), exp_on.size());
        for (int i = 0; i < exp_on.size() && i < obs_on.size(); i++)
            check({tag, "_osd_on"}, obs_on[i], exp_on[i]);
`endif
    endtask

    initial begin
        logic [15:0] burst [4];
        logic [15:0] w, first;
        int          len, ntx;

        cmd_if.cmd_valid = 0; cmd_if.cmd_data = 0; cmd_if.cmd_last = 0;

        // ---- Reset state
        repeat (3) @(posedge clk);
        #1; rst = 0;
        @(negedge clk);
        check("rst_osd", io_osd, 0);
        check("rst_strobe", io_strobe, 0);
        check("rst_din", io_din, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_if.cmd_ready, 1);
`ifdef OSD_SEQ_SHADOW_EN
        check("rst_osd_on", osd_on, 0);
`endif
        @(posedge clk); #1;
        clear_obs(); mon_en = 1;

        // ---- 1: single enable word
        push_word(16'h0041, 1'b1); note_txn(16'h0041);
        wait_idle(200);
        check("t1_latency", obs_rise.size() > 0 ? obs_rise[0] - push_cyc : -1, SETUP + 2);
        check_stream("t1");
        check("t1_frames", osd_rises, 1);

        // ---- 2: back-to-back write burst
        clear_obs();
        burst[0] = 16'h0020; burst[1] = 16'h00AA; burst[2] = 16'h0055; burst[3] = 16'h00FF;
        for (int i = 0; i < 4; i++) push_word(burst[i], i == 3);
        note_txn(burst[0]);
        wait_idle(300);
        check_stream("t2");
        check("t2_frames", osd_rises, 1);
        for (int i = 1; i < obs_rise.size(); i++)
            check("t2_period", obs_rise[i] - obs_rise[i-1], 1 + 2 * STB);

        // ---- 3/6: fill the FIFO, push+pop at DEPTH-1, then underrun stall
        // Pops fall on the 5th push edge and every 5 edges after.
        clear_obs();
        for (int i = 0; i < 18; i++) push_word(16'h0100 + 16'(i), 1'b0);
        check("t6_ready_pre", cmd_if.cmd_ready, 1);
        @(posedge clk); #1;
        push_word(16'h0100 + 16'd18, 1'b0);
        check("t6_ready_pushpop", cmd_if.cmd_ready, 1);
        push_word(16'h0100 + 16'd19, 1'b0);
        check("t3_ready_full", cmd_if.cmd_ready, 0);
        repeat (3) begin @(posedge clk); #1; check("t3_ready_hold", cmd_if.cmd_ready, 0); end
        @(posedge clk); #1;
        check("t3_ready_after_pop", cmd_if.cmd_ready, 1);
        for (int i = 20; i < 24; i++) push_word(16'h0100 + 16'(i), 1'b0);
        wait_strobes(24, 600);
        repeat (20) @(posedge clk);
        #1;
        check("t3_stall_osd", io_osd, 1);
        check("t3_stall_strobe", io_strobe, 0);
        check("t3_stall_din", io_din, 16'h0117);
        check("t3_stall_busy", busy, 1);
        push_word(16'h0001, 1'b1); note_txn(16'h0100);
        wait_idle(300);
        check_stream("t3");
        check("t3_frames", osd_rises, 1);

        // ---- 4: reset during HI of word 2 of 4
        clear_obs();
        push_word(16'h0020, 0); push_word(16'h0011, 0); push_word(16'h0022, 0); push_word(16'h0033, 1);
        len = 0;
        while (!(obs_din.size() == 2 && io_strobe) && len < 200) begin @(negedge clk); #1; len++; end
        check("t4_reached_hi", io_strobe, 1);
        mon_en = 0; rst = 1;
        @(negedge clk); #1;
        check("t4_osd", io_osd, 0);
        check("t4_strobe", io_strobe, 0);
        check("t4_din", io_din, 0);
        check("t4_busy", busy, 0);
        check("t4_ready", cmd_if.cmd_ready, 1);
        @(posedge clk); #1; rst = 0; model_on = 0;
        clear_obs(); mon_en = 1;
        push_word(16'h0041, 1'b1); note_txn(16'h0041);
        wait_idle(200);
        check("t4_latency", obs_rise.size() > 0 ? obs_rise[0] - push_cyc : -1, SETUP + 2);
        check_stream("t4");

        // ---- 5: two queued transactions, disable then enable
        clear_obs();
        push_word(16'h0040, 1'b1); note_txn(16'h0040);
        push_word(16'h0041, 1'b1); note_txn(16'h0041);
        wait_idle(300);
        check_stream("t5");
        check("t5_frames", osd_rises, 2);
        check("t5_gap_count", obs_gap.size(), 1);
        foreach (obs_gap[i]) check("t5_gap", obs_gap[i], GAP);

        // ---- Random transactions with random host pacing
        clear_obs();
        ntx = 8;
        for (int t = 0; t < ntx; t++) begin
            len = $urandom_range(1, 5);
            case ($urandom_range(0, 2))
                0:       first = {8'h00, 4'h4, 4'($urandom_range(0, 15))};
                1:       first = {8'h00, 4'h2, 4'($urandom_range(0, 15))};
                default: first = 16'($urandom);
            endcase
            for (int k = 0; k < len; k++) begin
                w = (k == 0) ? first : 16'($urandom);
                repeat ($urandom_range(0, 6)) @(posedge clk);
                #1;
                push_word(w, k == len - 1);
            end
            note_txn(first);
        end
        wait_idle(2000);
        check_stream("rnd");
        check("rnd_frames", osd_rises, ntx);
        foreach (obs_gap[i]) check("rnd_gap_min", obs_gap[i] >= GAP, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
